// File: rtl/count_mode_detector_pkg.sv
// ---------------------------------------------------------------------------
// count_mode_detector_pkg
// Shared encodings for the multimode counter and its output observer.
// The mode codes match the counter's mode-select input, so the counter and
// the detector decode them identically.
// ---------------------------------------------------------------------------
package count_mode_detector_pkg;

    localparam int DEF_CW       = 4;
    localparam int DEF_LOCK_LEN = 4;
    localparam int DEF_ERR_W    = 8;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_UPDOWN = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        STEP_INC  = 2'b00,
        STEP_DEC  = 2'b01,
        STEP_HOLD = 2'b10,
        STEP_BAD  = 2'b11
    } step_e;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'b00,
        S_ACQ    = 2'b01,
        S_LOCKED = 2'b10
    } state_e;

    // Mode suggested by a single step. A legal reversal can only come from
    // an up/down counter, so it outranks the raw direction.
    function automatic mode_e step_to_mode(step_e cls, logic legal_rev);
        mode_e m;
        m = MODE_HOLD;
        if (legal_rev) begin
            m = MODE_UPDOWN;
        end else begin
            case (cls)
                STEP_INC: m = MODE_UP;
                STEP_DEC: m = MODE_DOWN;
                default:  m = MODE_HOLD;
            endcase
        end
        return m;
    endfunction

    // True when the step could have been produced by a counter in mode m.
    // cls must already have illegal reversals folded into STEP_BAD.
    function automatic logic step_fits_mode(mode_e m, step_e cls, logic legal_rev);
        logic fits;
        fits = 1'b0;
        case (m)
            MODE_UP:     fits = (cls == STEP_INC) && !legal_rev;
            MODE_DOWN:   fits = (cls == STEP_DEC) && !legal_rev;
            MODE_HOLD:   fits = (cls == STEP_HOLD);
            MODE_UPDOWN: fits = (cls != STEP_BAD);
            default:     fits = 1'b0;
        endcase
        return fits;
    endfunction

endpackage

// File: rtl/count_mode_detector_if.sv
// ---------------------------------------------------------------------------
// count_mode_detector_if
// Sample stream into the detector and status back out.
//   master : drives clr, sample_valid, count_in; reads status
//   slave  : the detector itself
// Signals:
//   clr          synchronous clear of the detector
//   sample_valid count_in carries a new counter sample
//   count_in     observed counter value (CW bits)
//   mode         inferred mode (UP/DOWN/UPDOWN/HOLD)
//   locked       mode is trustworthy
//   dir          1 = last non-hold step was an increment
//   turn         pulse on a legal boundary reversal
//   step_err     pulse on an illegal step
//   err_cnt      saturating count of step_err pulses (ERR_W bits)
// ---------------------------------------------------------------------------
interface count_mode_detector_if #(
    parameter int CW    = 4,
    parameter int ERR_W = 8
);
    logic             clr;
    logic             sample_valid;
    logic [CW-1:0]    count_in;
    logic [1:0]       mode;
    logic             locked;
    logic             dir;
    logic             turn;
    logic             step_err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output clr, sample_valid, count_in,
        input  mode, locked, dir, turn, step_err, err_cnt
    );

    modport slave (
        input  clr, sample_valid, count_in,
        output mode, locked, dir, turn, step_err, err_cnt
    );
endinterface

// File: rtl/count_mode_detector_step_classifier.sv
// ---------------------------------------------------------------------------
// count_mode_detector_step_classifier
// Combinational step decode between the previous and current sample.
// Ports:
//   prev_i        last captured sample
//   count_i       new sample
//   step_o        INC (+1), DEC (-1), HOLD (0) or BAD, all modulo 2**CW
//   vertex_min_o  prev_i is zero (legal DEC->INC turning point)
//   vertex_max_o  prev_i is all-ones (legal INC->DEC turning point)
// ---------------------------------------------------------------------------
module count_mode_detector_step_classifier
    import count_mode_detector_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] prev_i,
    input  logic [CW-1:0] count_i,
    output step_e         step_o,
    output logic          vertex_min_o,
    output logic          vertex_max_o
);

    logic [CW-1:0] delta;

    // Modulo subtraction makes max->0 and 0->max ordinary single steps.
    always_comb begin
        delta = count_i - prev_i;
        if (delta == CW'(1)) begin
            step_o = STEP_INC;
        end else if (delta == '1) begin
            step_o = STEP_DEC;
        end else if (delta == '0) begin
            step_o = STEP_HOLD;
        end else begin
            step_o = STEP_BAD;
        end
    end

    assign vertex_min_o = (prev_i == '0);
    assign vertex_max_o = (prev_i == '1);

endmodule

// File: rtl/count_mode_detector.sv
// ---------------------------------------------------------------------------
// count_mode_detector
// Watches the multimode counter output, infers its mode and direction,
// flags illegal steps and keeps a saturating error count.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  count_mode_detector_if.slave (sample stream in, status out)
// All status outputs are registered and update on the edge that captures
// a valid sample.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_EMPTY  | no previous sample yet; next valid sample only loads prev
// S_ACQ    | building a run of steps agreeing with a candidate mode
// S_LOCKED | LOCK_LEN agreeing steps seen; mode output is trustworthy
// ---------------------------------------------------------------------------
module count_mode_detector
    import count_mode_detector_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int LOCK_LEN = DEF_LOCK_LEN,
    parameter int ERR_W    = DEF_ERR_W
) (
    input logic                 clk,
    input logic                 rst,
    count_mode_detector_if.slave bus
);

    localparam int RUN_W = $clog2(LOCK_LEN + 1);

    state_e           state_q;
    logic [CW-1:0]    prev_q;
    logic             has_dir_q;
    mode_e            cand_q;
    mode_e            mode_q;
    logic [RUN_W-1:0] run_q;
    logic             locked_q;
    logic             dir_q;
    logic             turn_q;
    logic             step_err_q;
    logic [ERR_W-1:0] err_cnt_q;

    step_e            raw_step;
    logic             vertex_min;
    logic             vertex_max;

    logic             rev_d;
    logic             legal_rev_d;
    step_e            step_d;
    mode_e            cand_d;
    logic             cand_match_d;
    logic             mode_match_d;
    logic [RUN_W-1:0] run_d;
    logic             lock_d;

    count_mode_detector_step_classifier #(
        .CW (CW)
    ) u_classifier (
        .prev_i       (prev_q),
        .count_i      (bus.count_in),
        .step_o       (raw_step),
        .vertex_min_o (vertex_min),
        .vertex_max_o (vertex_max)
    );

    // has_dir_q qualifies dir_q as "a real previous direction exists"; it is
    // cleared on reset/clear and on a BAD step so a discontinuity is never
    // mistaken for one side of a reversal.
    always_comb begin
        rev_d        = has_dir_q && ((raw_step == STEP_INC && !dir_q) ||
                                     (raw_step == STEP_DEC &&  dir_q));
        legal_rev_d  = rev_d && ((raw_step == STEP_INC && vertex_min) ||
                                 (raw_step == STEP_DEC && vertex_max));
        step_d       = (rev_d && !legal_rev_d) ? STEP_BAD : raw_step;
        cand_d       = step_to_mode(step_d, legal_rev_d);
        // run_q == 0 means no candidate is held yet
        cand_match_d = (run_q != '0) && step_fits_mode(cand_q, step_d, legal_rev_d);
        mode_match_d = step_fits_mode(mode_q, step_d, legal_rev_d);
        run_d        = cand_match_d ? run_q + RUN_W'(1) : RUN_W'(1);
        lock_d       = (run_d == RUN_W'(LOCK_LEN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            prev_q     <= '0;
            has_dir_q  <= 1'b0;
            cand_q     <= MODE_HOLD;
            mode_q     <= MODE_HOLD;
            run_q      <= '0;
            locked_q   <= 1'b0;
            dir_q      <= 1'b1;
            turn_q     <= 1'b0;
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            turn_q     <= 1'b0;
            step_err_q <= 1'b0;
            if (bus.clr) begin
                state_q   <= S_EMPTY;
                prev_q    <= '0;
                has_dir_q <= 1'b0;
                cand_q    <= MODE_HOLD;
                mode_q    <= MODE_HOLD;
                run_q     <= '0;
                locked_q  <= 1'b0;
                dir_q     <= 1'b1;
                err_cnt_q <= '0;
            end else if (bus.sample_valid) begin
                prev_q <= bus.count_in;
                case (state_q)
                    S_EMPTY: begin
                        state_q <= S_ACQ;
                    end
                    default: begin
                        if (step_d == STEP_BAD) begin
                            step_err_q <= 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_q <= err_cnt_q + ERR_W'(1);
                            end
                            locked_q  <= 1'b0;
                            run_q     <= '0;
                            has_dir_q <= 1'b0;
                            state_q   <= S_ACQ;
                        end else begin
                            turn_q <= legal_rev_d;
                            if (step_d == STEP_INC) begin
                                dir_q     <= 1'b1;
                                has_dir_q <= 1'b1;
                            end else if (step_d == STEP_DEC) begin
                                dir_q     <= 1'b0;
                                has_dir_q <= 1'b1;
                            end

                            if (state_q == S_LOCKED) begin
                                if (!mode_match_d) begin
                                    // mode stays at its old value until relock
                                    locked_q <= 1'b0;
                                    cand_q   <= cand_d;
                                    run_q    <= RUN_W'(1);
                                    state_q  <= S_ACQ;
                                end
                            end else begin
                                // an UPDOWN candidate absorbs later INC/DEC/HOLD
                                // steps rather than being replaced by them
                                if (!cand_match_d) begin
                                    cand_q <= cand_d;
                                end
                                run_q <= run_d;
                                if (lock_d) begin
                                    locked_q <= 1'b1;
                                    mode_q   <= cand_match_d ? cand_q : cand_d;
                                    state_q  <= S_LOCKED;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.mode     = mode_q;
    assign bus.locked   = locked_q;
    assign bus.dir      = dir_q;
    assign bus.turn     = turn_q;
    assign bus.step_err = step_err_q;
    assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_count_mode_detector.sv
module tb_count_mode_detector;

    localparam int CW       = 4;
    localparam int LOCK_LEN = 4;
    localparam int ERR_W    = 8;
    localparam int CMAX     = (1 << CW) - 1;
    localparam int EMAX     = (1 << ERR_W) - 1;

    logic clk;
    logic rst;

    count_mode_detector_if #(.CW(CW), .ERR_W(ERR_W)) bus ();

    count_mode_detector #(
        .CW       (CW),
        .LOCK_LEN (LOCK_LEN),
        .ERR_W    (ERR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    // ---------------- reference model (integer arithmetic) ----------------
    // m_lastdir: +1 / -1 direction of last non-hold step, 0 = none known
    int m_mode = 3, m_locked = 0, m_dir = 1, m_turn = 0, m_err = 0, m_cnt = 0;
    int m_have_prev = 0, m_prev = 0, m_lastdir = 0, m_run = 0, m_cand = 3;

    function automatic int mode_of(int kind, int rev);
        if (rev != 0) return 2;
        if (kind == 1) return 0;
        if (kind == -1) return 1;
        return 3;
    endfunction

    function automatic int fits(int m, int kind, int rev);
        case (m)
            0: return (kind == 1 && rev == 0) ? 1 : 0;
            1: return (kind == -1 && rev == 0) ? 1 : 0;
            3: return (kind == 0) ? 1 : 0;
            default: return 1;
        endcase
    endfunction

    task automatic m_reset();
        m_mode = 3; m_locked = 0; m_dir = 1; m_turn = 0; m_err = 0; m_cnt = 0;
        m_have_prev = 0; m_prev = 0; m_lastdir = 0; m_run = 0; m_cand = 3;
    endtask

    task automatic m_sample(input int v);
        int d, kind, rev, legal, this_mode;
        if (m_have_prev == 0) begin
            m_have_prev = 1;
            m_prev = v;
            return;
        end
        d = (v - m_prev) & CMAX;
        if (d == 1)         kind = 1;
        else if (d == CMAX) kind = -1;
        else if (d == 0)    kind = 0;
        else                kind = 2;
        rev   = (kind != 0 && kind != 2 && m_lastdir != 0 && kind == -m_lastdir) ? 1 : 0;
        legal = ((kind == -1 && m_prev == CMAX) || (kind == 1 && m_prev == 0)) ? 1 : 0;
        if (rev != 0 && legal == 0) kind = 2;
        if (kind == 2) begin
            m_err = 1;
            m_cnt = (m_cnt < EMAX) ? m_cnt + 1 : EMAX;
            m_locked = 0;
            m_run = 0;
            m_lastdir = 0;
        end else begin
            m_turn = rev;
            if (kind != 0) begin
                m_dir = (kind > 0) ? 1 : 0;
                m_lastdir = kind;
            end
            this_mode = mode_of(kind, rev);
            if (m_locked != 0) begin
                if (fits(m_mode, kind, rev) == 0) begin
                    m_locked = 0;
                    m_cand = this_mode;
                    m_run = 1;
                end
            end else begin
                if (m_run > 0 && fits(m_cand, kind, rev) != 0) m_run++;
                else begin
                    m_cand = this_mode;
                    m_run = 1;
                end
                if (m_run == LOCK_LEN) begin
                    m_locked = 1;
                    m_mode = m_cand;
                end
            end
        end
        m_prev = v;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) m_reset();
        else if (bus.clr) m_reset();
        else begin
            m_turn = 0;
            m_err = 0;
            if (bus.sample_valid) m_sample(int'(bus.count_in));
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cmp_mode",     32'(bus.mode),     m_mode);
            chk("cmp_locked",   32'(bus.locked),   m_locked);
            chk("cmp_dir",      32'(bus.dir),      m_dir);
            chk("cmp_turn",     32'(bus.turn),     m_turn);
            chk("cmp_step_err", 32'(bus.step_err), m_err);
            chk("cmp_err_cnt",  32'(bus.err_cnt),  m_cnt);
        end
    end

    task automatic lit_reset(input string tag);
        chk({tag, "_mode"},     32'(bus.mode),     3);
        chk({tag, "_locked"},   32'(bus.locked),   0);
        chk({tag, "_dir"},      32'(bus.dir),      1);
        chk({tag, "_turn"},     32'(bus.turn),     0);
        chk({tag, "_step_err"}, 32'(bus.step_err), 0);
        chk({tag, "_err_cnt"},  32'(bus.err_cnt),  0);
    endtask

    // ---------------- stimulus ----------------
    task automatic put(input int v);
        bus.sample_valid = 1'b1;
        bus.count_in     = CW'(v);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        bus.sample_valid = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_clr();
        bus.clr          = 1'b1;
        bus.sample_valid = 1'b1;
        bus.count_in     = CW'(7);
        @(posedge clk);
        #2;
        bus.clr          = 1'b0;
        bus.sample_valid = 1'b0;
        lit_reset("clr");
    endtask

    int v;

    initial begin
        rst              = 1'b1;
        bus.clr          = 1'b0;
        bus.sample_valid = 1'b0;
        bus.count_in     = '0;
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1;
        lit_reset("rst");
        rst = 1'b0;
        idle(1);

        // up stream with wrap
        for (int i = 0; i < 18; i++) begin
            put(i % 16);
            if (i == 3) chk("up_pre_lock", 32'(bus.locked), 0);
            if (i == 4) begin
                chk("up_lock",      32'(bus.locked), 1);
                chk("up_lock_mode", 32'(bus.mode),   0);
            end
            if (i == 16) chk("up_wrap_no_err", 32'(bus.step_err), 0);
        end
        chk("up_err_cnt", 32'(bus.err_cnt), 0);

        // clear with a simultaneous sample, then down stream with wrap
        do_clr();
        put(3);
        chk("clr_first_loads", 32'(bus.step_err), 0);
        put(2); put(1); put(0);
        chk("down_pre_lock", 32'(bus.locked), 0);
        put(15);
        chk("down_lock",      32'(bus.locked), 1);
        chk("down_mode",      32'(bus.mode),   1);
        chk("down_dir",       32'(bus.dir),    0);
        put(14);
        chk("down_err_cnt",   32'(bus.err_cnt), 0);

        // hold steps unlock DOWN without an error and relock as HOLD
        put(14);
        chk("hold_unlock",  32'(bus.locked),   0);
        chk("hold_no_err",  32'(bus.step_err), 0);
        put(14); put(14); put(14);
        chk("hold_lock",      32'(bus.locked), 1);
        chk("hold_lock_mode", 32'(bus.mode),   3);
        chk("hold_dir_kept",  32'(bus.dir),    0);

        // bounce at the top vertex
        do_clr();
        put(12); put(13); put(14); put(15);
        put(14);
        chk("bounce_turn", 32'(bus.turn), 1);
        put(13);
        chk("bounce_turn_end", 32'(bus.turn), 0);
        put(12); put(11);
        chk("bounce_lock",      32'(bus.locked),  1);
        chk("bounce_lock_mode", 32'(bus.mode),    2);
        chk("bounce_no_err",    32'(bus.err_cnt), 0);
        // reversal at an interior vertex
        put(10); put(9); put(8); put(9);
        chk("midrev_err",     32'(bus.step_err), 1);
        chk("midrev_err_cnt", 32'(bus.err_cnt),  1);
        chk("midrev_unlock",  32'(bus.locked),   0);
        chk("midrev_mode",    32'(bus.mode),     2);
        put(8);
        chk("midrev_err_end", 32'(bus.step_err), 0);

        // locked UP, then a jump
        do_clr();
        put(1); put(2); put(3); put(4); put(5);
        chk("jump_pre_lock", 32'(bus.locked), 1);
        put(9);
        chk("jump_err",     32'(bus.step_err), 1);
        chk("jump_err_cnt", 32'(bus.err_cnt),  1);
        chk("jump_unlock",  32'(bus.locked),   0);
        idle(2);
        chk("idle_err_clr", 32'(bus.step_err), 0);
        put(10); put(11); put(12);
        chk("relock_pending", 32'(bus.locked), 0);
        put(13);
        chk("relock",      32'(bus.locked), 1);
        chk("relock_mode", 32'(bus.mode),   0);

        // error counter saturation
        v = 13;
        for (int i = 0; i < 300; i++) begin
            v = (v + 4) & CMAX;
            put(v);
            if (i == 252) chk("sat_254", 32'(bus.err_cnt), 254);
            if (i == 253) chk("sat_255", 32'(bus.err_cnt), 255);
        end
        chk("sat_hold",     32'(bus.err_cnt),  255);
        chk("sat_step_err", 32'(bus.step_err), 1);

        // async reset while locked
        idle(1);
        put(0); put(1); put(2); put(3); put(4);
        chk("pre_rst_lock", 32'(bus.locked), 1);
        bus.sample_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        lit_reset("async_rst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        put(9);
        chk("post_rst_load_err",    32'(bus.step_err), 0);
        chk("post_rst_load_locked", 32'(bus.locked),   0);
        put(10);
        chk("post_rst_step_err", 32'(bus.step_err), 0);
        chk("post_rst_err_cnt",  32'(bus.err_cnt),  0);
        idle(2);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
